// File: rtl/eth_pkg.sv
// Shared types for the Ethernet-style port path.
// The word format is common to the transmit and receive FSMs.
package eth_pkg;

    localparam int ETH_DW = 32;
    localparam int ETH_WW = 34;

    localparam logic [ETH_DW-1:0] DEF_PORTA_ADDR = 32'hABCD;
    localparam logic [ETH_DW-1:0] DEF_PORTB_ADDR = 32'h1234;

    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [ETH_DW-1:0] data;
    } eth_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRC,
        ST_DATA,
        ST_DISCARD,
        ST_GAP
    } eth_tx_state_t;

endpackage

// File: rtl/eth_tx_out_stage.sv
// Valid/ready holding register for the transmit port.
// A word stays put until accepted; load and accept may coincide.
module eth_tx_out_stage
    import eth_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              load,
    input  eth_word_t         ld_word,
    input  logic              ld_port,
    input  logic              tx_ready,
    output logic              load_ok,
    output logic              tx_valid,
    output logic [ETH_DW-1:0] tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              tx_port
);

    logic      valid_q, valid_d;
    eth_word_t word_q, word_d;
    logic      port_q, port_d;

    assign load_ok = !valid_q || tx_ready;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        port_d  = port_q;
        if (load) begin
            valid_d = 1'b1;
            word_d  = ld_word;
            port_d  = ld_port;
        end else if (tx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            port_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            port_q  <= port_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = word_q.data;
    assign tx_sop   = word_q.sop;
    assign tx_eop   = word_q.eop;
    assign tx_port  = port_q;

endmodule

// File: rtl/eth_tx_fsm.sv
// Packet transmitter: drains an FWFT FIFO, filters by destination,
// frames accepted packets and inserts an inter-packet gap.
module eth_tx_fsm
    import eth_pkg::*;
#(
    parameter logic [ETH_DW-1:0] PORTA_ADDR = DEF_PORTA_ADDR,
    parameter logic [ETH_DW-1:0] PORTB_ADDR = DEF_PORTB_ADDR,
    parameter int                IPG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              fifo_empty,
    input  logic [ETH_WW-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [ETH_DW-1:0] tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              tx_port,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam logic [7:0] GAP_INIT =
        (IPG_CYCLES == 0) ? 8'd0 : 8'(IPG_CYCLES - 1);

    eth_tx_state_t state_q, state_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   pkt_q, pkt_d;
    logic [15:0]   drop_q, drop_d;

    eth_word_t head;
    eth_word_t ld_word;
    logic      ld_port;
    logic      load;
    logic      load_ok;
    logic      pop;
    logic      is_a, is_b;

    assign head = eth_word_t'(fifo_rd_data);
    assign is_a = (head.data == PORTA_ADDR);
    assign is_b = (head.data == PORTB_ADDR);

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pkt_d       = pkt_q;
        drop_d      = drop_q;
        pop         = 1'b0;
        load        = 1'b0;
        ld_word     = head;
        ld_word.sop = 1'b0;
        ld_port     = tx_port;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!head.sop || head.eop) begin
                        pop    = 1'b1;
                        drop_d = drop_q + 16'd1;
                    end else if (is_a || is_b) begin
                        if (load_ok) begin
                            pop         = 1'b1;
                            load        = 1'b1;
                            ld_word.sop = 1'b1;
                            ld_port     = is_b;
                            state_d     = ST_SRC;
                        end
                    end else begin
                        pop     = 1'b1;
                        drop_d  = drop_q + 16'd1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_SRC, ST_DATA: begin
                if (!fifo_empty && load_ok) begin
                    pop  = 1'b1;
                    load = 1'b1;
                    if (head.eop) begin
                        pkt_d   = pkt_q + 16'd1;
                        gap_d   = GAP_INIT;
                        state_d = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DISCARD: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.eop) state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            gap_q   <= 8'd0;
            pkt_q   <= 16'd0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    // IDLE drains strays even during reset unless gated here
    assign fifo_rd_en = pop && rstN;
    assign pkt_cnt    = pkt_q;
    assign drop_cnt   = drop_q;

    eth_tx_out_stage u_out (
        .clk      (clk),
        .rstN     (rstN),
        .load     (load),
        .ld_word  (ld_word),
        .ld_port  (ld_port),
        .tx_ready (tx_ready),
        .load_ok  (load_ok),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_port  (tx_port)
    );

endmodule

// File: tb/tb_eth_tx_fsm.sv
// Bench for eth_tx_fsm: FIFO models, output scoreboard, gap timing.
// A second instance with IPG_CYCLES=0 checks the no-gap path.
module tb_eth_tx_fsm;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic        fe_a, ren_a, rdy_a, v_a, sop_a, eop_a, port_a;
    logic [33:0] rdd_a;
    logic [31:0] d_a;
    logic [15:0] pc_a, dc_a;

    logic        fe_0, ren_0, rdy_0, v_0, sop_0, eop_0, port_0;
    logic [33:0] rdd_0;
    logic [31:0] d_0;
    logic [15:0] pc_0, dc_0;

    logic [33:0] mem_a [256];
    logic [33:0] mem_0 [256];
    int wp_a = 0, rp_a = 0, wp_0 = 0, rp_0 = 0;

    assign fe_a  = (wp_a == rp_a);
    assign rdd_a = mem_a[rp_a[7:0]];
    assign fe_0  = (wp_0 == rp_0);
    assign rdd_0 = mem_0[rp_0[7:0]];

    eth_tx_fsm #(.IPG_CYCLES(4)) u_dut (
        .clk(clk), .rstN(rstN),
        .fifo_empty(fe_a), .fifo_rd_data(rdd_a), .fifo_rd_en(ren_a),
        .tx_ready(rdy_a), .tx_valid(v_a), .tx_data(d_a),
        .tx_sop(sop_a), .tx_eop(eop_a), .tx_port(port_a),
        .pkt_cnt(pc_a), .drop_cnt(dc_a)
    );

    eth_tx_fsm #(.IPG_CYCLES(0)) u_dut0 (
        .clk(clk), .rstN(rstN),
        .fifo_empty(fe_0), .fifo_rd_data(rdd_0), .fifo_rd_en(ren_0),
        .tx_ready(rdy_0), .tx_valid(v_0), .tx_data(d_0),
        .tx_sop(sop_0), .tx_eop(eop_0), .tx_port(port_0),
        .pkt_cnt(pc_0), .drop_cnt(dc_0)
    );

    int cyc = 0;
    int last_eop_a = 0, gap_a = -1;
    int last_eop_0 = 0, gap_0 = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren_a) begin
            rp_a <= rp_a + 1;
            if (rdd_a[33]) last_eop_a <= cyc;
            if (rdd_a[32]) gap_a <= cyc - last_eop_a - 1;
        end
        if (ren_0) begin
            rp_0 <= rp_0 + 1;
            if (rdd_0[33]) last_eop_0 <= cyc;
            if (rdd_0[32]) gap_0 <= cyc - last_eop_0 - 1;
        end
    end

    logic [34:0] expq [$];
    int n_cmp = 0;
    int n_err = 0;
    bit hold_chk = 1'b0;
    int vcnt = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            if (v_a) vcnt++;
            if (hold_chk && v_a && !rdy_a) check("hold_rden", ren_a, 0);
            if (ren_a && fe_a) check("rden_empty", 1, 0);
            if (v_a && rdy_a) begin
                if (expq.size() == 0) begin
                    check("unexpected_out", {port_a, sop_a, eop_a, d_a}, 0);
                end else begin
                    logic [34:0] e;
                    e = expq.pop_front();
                    check("tx_word", {port_a, sop_a, eop_a, d_a}, e);
                end
            end
        end
    end

    task automatic word_a(input logic e, input logic s, input logic [31:0] d,
                          input logic prt, input bit exp_out);
        mem_a[wp_a[7:0]] = {e, s, d};
        wp_a++;
        if (exp_out) expq.push_back({prt, s, e, d});
    endtask

    task automatic pkt_a(input logic [31:0] addr, input int n,
                         input logic [31:0] base, input bit exp_out);
        for (int i = 0; i < n; i++) begin
            word_a(i == n - 1, i == 0, (i == 0) ? addr : base + i,
                   addr == DEF_PORTB_ADDR, exp_out);
        end
    endtask

    task automatic pkt_0(input logic [31:0] addr, input int n,
                         input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem_0[wp_0[7:0]] = {i == n - 1, i == 0,
                                (i == 0) ? addr : base + i};
            wp_0++;
        end
    endtask

    task automatic drain_a(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && fe_a && !v_a) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic drain_0(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fe_0 && !v_0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    initial begin
        bit drained;
        rdy_a = 1'b1;
        rdy_0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", v_a, 0);
        check("rst_sop_eop_port", {sop_a, eop_a, port_a}, 0);
        check("rst_data", d_a, 0);
        check("rst_cnts", {pc_a, dc_a}, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // port A packet, ready high
        vcnt = 0;
        word_a(1'b0, 1'b1, 32'hABCD, 1'b0, 1'b1);
        word_a(1'b0, 1'b0, 32'h5555, 1'b0, 1'b1);
        word_a(1'b0, 1'b0, 32'h1111, 1'b0, 1'b1);
        word_a(1'b1, 1'b0, 32'h2222, 1'b0, 1'b1);
        drain_a("a_drain");
        check("a_valid_cycles", vcnt, 4);
        check("a_pkt_cnt", pc_a, 1);
        check("a_port", port_a, 0);
        check("a_drop_cnt", dc_a, 0);

        // port B packet with ready toggling 1,0,0,1
        pkt_a(DEF_PORTB_ADDR, 4, 32'h100, 1'b1);
        hold_chk = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (expq.size() == 0 && fe_a && !v_a) begin
                drained = 1'b1;
                break;
            end
            rdy_a = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
        end
        rdy_a = 1'b1;
        hold_chk = 1'b0;
        check("b_drain", drained, 1);
        check("b_pkt_cnt", pc_a, 2);
        check("b_port", port_a, 1);

        // unknown destination, then a valid packet
        pkt_a(32'hDEAD, 4, 32'h200, 1'b0);
        pkt_a(DEF_PORTB_ADDR, 3, 32'h300, 1'b1);
        drain_a("disc_drain");
        check("disc_drop_cnt", dc_a, 1);
        check("disc_pkt_cnt", pc_a, 3);

        // strays and a malformed one-word packet
        word_a(1'b0, 1'b0, 32'h77, 1'b0, 1'b0);
        word_a(1'b0, 1'b0, 32'h88, 1'b0, 1'b0);
        word_a(1'b1, 1'b1, 32'hABCD, 1'b0, 1'b0);
        drain_a("stray_drain");
        repeat (2) @(negedge clk);
        check("stray_drop_cnt", dc_a, 4);
        check("stray_pkt_cnt", pc_a, 3);

        // back-to-back packets: gap of 4 and of 0
        pkt_a(DEF_PORTA_ADDR, 3, 32'h400, 1'b1);
        pkt_a(DEF_PORTB_ADDR, 3, 32'h500, 1'b1);
        pkt_0(DEF_PORTA_ADDR, 3, 32'h400);
        pkt_0(DEF_PORTB_ADDR, 3, 32'h500);
        drain_a("gap4_drain");
        drain_0("gap0_drain");
        check("gap4_cycles", gap_a, 4);
        check("gap0_cycles", gap_0, 0);
        check("gap4_pkt_cnt", pc_a, 5);
        check("gap0_pkt_cnt", pc_0, 2);

        // reset in the middle of a 5-word packet
        word_a(1'b0, 1'b1, DEF_PORTB_ADDR, 1'b1, 1'b1);
        word_a(1'b0, 1'b0, 32'h601, 1'b1, 1'b1);
        drain_a("mid_drain");
        check("mid_port", port_a, 1);
        @(posedge clk); #1;
        rstN = 1'b0;
        word_a(1'b0, 1'b0, 32'h602, 1'b1, 1'b0);
        word_a(1'b0, 1'b0, 32'h603, 1'b1, 1'b0);
        word_a(1'b1, 1'b0, 32'h604, 1'b1, 1'b0);
        @(negedge clk);
        check("mrst_valid", v_a, 0);
        check("mrst_sop_eop_port", {sop_a, eop_a, port_a}, 0);
        check("mrst_data", d_a, 0);
        check("mrst_cnts", {pc_a, dc_a}, 0);
        check("mrst_rden", ren_a, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        drain_a("mrst_strays");
        check("mrst_drop_cnt", dc_a, 3);
        check("mrst_pkt_cnt0", pc_a, 0);
        pkt_a(DEF_PORTA_ADDR, 3, 32'h700, 1'b1);
        drain_a("resume_drain");
        check("resume_pkt_cnt", pc_a, 1);
        check("resume_drop_cnt", dc_a, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
